// File: rtl/lpddr2_pkg.sv
// Shared types and constants for the LPDDR2 request responder.
//
// Contents:
//   LP_ADDR_W / LP_DATA_W  widths of the CPU request bus; the responder's
//                          ADDR_W / DATA_W parameters default to these
//   ERR_DATA               read data returned when a read times out
//   resp_state_t           responder FSM states
//   lpddr2_req_t           one captured CPU request (address, write data,
//                          read flag, write flag)
package lpddr2_pkg;

  localparam int LP_ADDR_W = 27;
  localparam int LP_DATA_W = 32;

  localparam logic [LP_DATA_W-1:0] ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    WR_CMD,
    RD_CMD,
    RD_WAIT,
    ACK
  } resp_state_t;

  // A request with both flags set is a write followed by a read of the
  // same address, completed with a single acknowledge.
  typedef struct packed {
    logic [LP_ADDR_W-1:0] addr;
    logic [LP_DATA_W-1:0] wdata;
    logic                 is_rd;
    logic                 is_wr;
  } lpddr2_req_t;

endpackage

// File: rtl/lpddr2_req_capture.sv
// Request edge detection and one-deep pending slot.
//
// The CPU presents read/write requests as levels. A request is the rising
// edge of either level; the address and write data are captured in the
// cycle the edge is seen. The captured request waits in a single slot
// until the FSM pops it. An edge that arrives while the slot is occupied
// (and not being popped in the same cycle) is dropped and reported on
// `overflow`.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   address      CPU word address
//   write_data   CPU write data
//   rreq, wreq   CPU read / write request levels
//   pop          FSM takes the slot contents this cycle
//   req          slot contents
//   req_vld      slot holds a request
//   overflow     one-cycle pulse: an edge was dropped because the slot was full
module lpddr2_req_capture
  import lpddr2_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LP_ADDR_W-1:0] address,
  input  logic [LP_DATA_W-1:0] write_data,
  input  logic                 rreq,
  input  logic                 wreq,
  input  logic                 pop,
  output lpddr2_req_t          req,
  output logic                 req_vld,
  output logic                 overflow
);

  logic rreq_d;
  logic wreq_d;
  logic rd_rise;
  logic wr_rise;
  logic any_rise;
  logic slot_free;

  assign rd_rise   = rreq & ~rreq_d;
  assign wr_rise   = wreq & ~wreq_d;
  assign any_rise  = rd_rise | wr_rise;

  // A pop in the same cycle frees the slot for a simultaneous new edge.
  assign slot_free = ~req_vld | pop;
  assign overflow  = any_rise & ~slot_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rreq_d  <= 1'b0;
      wreq_d  <= 1'b0;
      req_vld <= 1'b0;
      req     <= '0;
    end else begin
      rreq_d <= rreq;
      wreq_d <= wreq;
      if (any_rise && slot_free) begin
        req_vld   <= 1'b1;
        req.addr  <= address;
        req.wdata <= write_data;
        req.is_rd <= rd_rise;
        req.is_wr <= wr_rise;
      end else if (pop) begin
        req_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lpddr2_responder.sv
// Memory-side responder for the CPU lpddr2_* request bus.
//
// Each CPU request (rising edge of lpddr2_rreq / lpddr2_wreq) becomes one
// Avalon-MM transaction toward the LPDDR2 controller. Read data is
// registered into lpddr2_read_data and every request completes with a
// one-cycle lpddr2_ack pulse. One transaction is in flight at a time; one
// more request can wait in the capture slot.
//
// Parameters:
//   ADDR_W   word address width
//   DATA_W   data width
//   TIMEOUT  cycles allowed from command issue to completion
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lpddr2_address      CPU word address
//   lpddr2_write_data   CPU write data
//   lpddr2_rreq/wreq    CPU read / write request levels
//   lpddr2_read_data    last read result (ERR_DATA after a read timeout)
//   lpddr2_ack          one-cycle completion pulse
//   avm_*               Avalon-MM master toward the controller
//   local_init_done     controller calibration complete
//   err                 sticky: timeout or dropped request since reset
module lpddr2_responder
  import lpddr2_pkg::*;
#(
  parameter int ADDR_W  = LP_ADDR_W,
  parameter int DATA_W  = LP_DATA_W,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   lpddr2_address,
  input  logic [DATA_W-1:0]   lpddr2_write_data,
  input  logic                lpddr2_rreq,
  input  logic                lpddr2_wreq,
  output logic [DATA_W-1:0]   lpddr2_read_data,
  output logic                lpddr2_ack,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                local_init_done,
  output logic                err
);

  // Wide enough to hold TIMEOUT, the value reached on the exit cycle.
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  resp_state_t       state;
  resp_state_t       state_nxt;

  lpddr2_req_t       req;
  logic              req_vld;
  logic              overflow;
  logic              pop;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_rd;

  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic              in_txn;
  logic              cmd_entry;
  logic              tmo_fire;
  logic              rd_tmo;
  logic              rd_capture;

  lpddr2_req_capture u_capture (
    .clk        (clk),
    .rst        (rst),
    .address    (lpddr2_address),
    .write_data (lpddr2_write_data),
    .rreq       (lpddr2_rreq),
    .wreq       (lpddr2_wreq),
    .pop        (pop),
    .req        (req),
    .req_vld    (req_vld),
    .overflow   (overflow)
  );

  // The command registers only change on a pop in IDLE, so address and
  // write data are inherently stable while a command is stalled.
  assign avm_address    = cur_addr;
  assign avm_writedata  = cur_wdata;
  assign avm_byteenable = '1;

  assign in_txn    = (state == WR_CMD) || (state == RD_CMD) || (state == RD_WAIT);
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  // The write-to-read hand-off of a paired request also restarts the count.
  assign cmd_entry = (state_nxt != state) &&
                     ((state_nxt == WR_CMD) || (state_nxt == RD_CMD));

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    avm_read   = 1'b0;
    avm_write  = 1'b0;
    lpddr2_ack = 1'b0;
    tmo_fire   = 1'b0;
    rd_tmo     = 1'b0;
    rd_capture = 1'b0;
    case (state)
      INIT: begin
        if (local_init_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (req_vld) begin
          pop       = 1'b1;
          state_nxt = req.is_wr ? WR_CMD : RD_CMD;
        end
      end
      WR_CMD: begin
        avm_write = 1'b1;
        // An accepted command wins over a timeout in the same cycle.
        if (!avm_waitrequest) begin
          state_nxt = cur_rd ? RD_CMD : ACK;
        end else if (tmo_hit) begin
          state_nxt = ACK;
          tmo_fire  = 1'b1;
        end
      end
      RD_CMD: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          state_nxt = RD_WAIT;
        end else if (tmo_hit) begin
          state_nxt = ACK;
          tmo_fire  = 1'b1;
          rd_tmo    = 1'b1;
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          state_nxt  = ACK;
          rd_capture = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = ACK;
          tmo_fire  = 1'b1;
          rd_tmo    = 1'b1;
        end
      end
      ACK: begin
        lpddr2_ack = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= INIT;
      cur_addr         <= '0;
      cur_wdata        <= '0;
      cur_rd           <= 1'b0;
      tmo_cnt          <= '0;
      lpddr2_read_data <= '0;
      err              <= 1'b0;
    end else begin
      state <= state_nxt;

      if (pop) begin
        cur_addr  <= req.addr;
        cur_wdata <= req.wdata;
        cur_rd    <= req.is_rd;
      end

      if (cmd_entry) begin
        tmo_cnt <= '0;
      end else if (in_txn) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      // Strobes outside RD_WAIT never reach here: rd_capture is only
      // raised in that state.
      if (rd_capture) begin
        lpddr2_read_data <= avm_readdata;
      end else if (rd_tmo) begin
        lpddr2_read_data <= ERR_DATA;
      end

      if (tmo_fire || overflow) err <= 1'b1;
    end
  end

endmodule

// File: doc/lpddr2_responder.md
# lpddr2_responder

Memory-side end of the CPU's `lpddr2_*` request bus. Detects level read/write requests from the CPU memory stage, converts each into one Avalon-MM transaction toward the LPDDR2 controller, and returns read data with a one-cycle completion pulse. Sits between the CPU top level and the vendor LPDDR2 controller IP; one transaction is in flight at a time, and at most one further request is queued.

## Interface
- `ADDR_W`, 27, word address width (matches `lpddr2_address`)
- `DATA_W`, 32, data width
- `TIMEOUT`, 1024, cycles allowed per transaction before error completion
- `clk`  in  1  single clock for all logic
- `rst`  in  1  reset, asynchronous, active-high
- `lpddr2_address`  in  ADDR_W  word address from the CPU
- `lpddr2_write_data`  in  DATA_W  write data from the CPU
- `lpddr2_rreq`  in  1  read request level
- `lpddr2_wreq`  in  1  write request level
- `lpddr2_read_data`  out  DATA_W  registered read result, held until the next read completes
- `lpddr2_ack`  out  1  one-cycle completion pulse
- `avm_address`  out  ADDR_W  controller address
- `avm_read`, `avm_write`  out  1  controller commands
- `avm_writedata`  out  DATA_W  controller write data
- `avm_byteenable`  out  DATA_W/8  constant all-ones
- `avm_waitrequest`  in  1  controller stall
- `avm_readdata`  in  DATA_W  controller read data
- `avm_readdatavalid`  in  1  read data strobe
- `local_init_done`  in  1  controller calibration complete
- `err`  out  1  sticky timeout flag, cleared only by `rst`

## Operation
- **Reset values:** all outputs 0 except `avm_byteenable`; state INIT; pending slot empty; edge-detect registers 0.
- **Request detection:**
  - A request is a rising edge of `rreq` or `wreq`, compared with its registered previous value.
  - Address and write data are captured in the cycle the edge is detected.
  - A level held high after `ack` does not retrigger.
- **Simultaneous edges:** when `rreq` and `wreq` rise together, the block performs the write, then the read to the same address. It issues a single `ack` after the read. The read returns the newly written data.
- **Pending slot:**
  - An edge detected outside IDLE is latched with its address and data into a one-deep pending slot, serviced on return to IDLE.
  - A further edge while the slot is full is dropped and sets `err`.
- **FSM:**
  - INIT → IDLE when `local_init_done` = 1. Edges seen in INIT are pended.
  - IDLE → WR_CMD on a write request; → RD_CMD on a read request; pending slot first.
  - WR_CMD: `avm_write` = 1 until `waitrequest` = 0. Then → RD_CMD if a paired read exists, else → ACK.
  - RD_CMD: `avm_read` = 1 until `waitrequest` = 0, then → RD_WAIT.
  - RD_WAIT: on `readdatavalid`, register `avm_readdata` into `lpddr2_read_data`, then → ACK.
  - ACK: `lpddr2_ack` = 1 for one cycle, then → IDLE.
- **Avalon rule:** `avm_address` and `avm_writedata` stay stable while a command is stalled by `waitrequest`.
- **Timeout:**
  - The counter resets on entry to WR_CMD or RD_CMD and runs through RD_WAIT.
  - At `TIMEOUT` the block sets `err`, loads `lpddr2_read_data` with `32'hDEADBEEF` (reads only), drops the commands, and goes → ACK.
- **Stray strobe:** `readdatavalid` outside RD_WAIT is ignored.
- **Reset mid-transaction:** commands are dropped immediately and the block returns to INIT. Any late `readdatavalid` is ignored.

## Timing
- Request edge present before clock edge N; detected at N.
- **Read, no stall:**
  - `avm_read` high during N+1 to N+2.
  - `readdatavalid` during N+2 to N+3.
  - `lpddr2_read_data` valid and `ack` high during N+3 to N+4.
  - Minimum read latency: 3 cycles.
- **Write, no stall:** `avm_write` high during N+1 to N+2; `ack` during N+2 to N+3.
- Each `waitrequest` cycle adds exactly one cycle. Each cycle of controller read latency adds one cycle.
- A pending request starts its command 1 cycle after the preceding ACK cycle (via IDLE).

## Structure
- **Package `lpddr2_pkg`:** state enum `resp_state_t` (INIT, IDLE, WR_CMD, RD_CMD, RD_WAIT, ACK), `ERR_DATA = 32'hDEADBEEF`, and the request struct {addr, wdata, is_rd, is_wr}.
- **Sub-module `lpddr2_req_capture`:** edge detection plus the one-deep pending slot. It outputs a request struct and a valid flag, and takes a pop input from the FSM.

## Test plan
- **Single write:** `init_done`=1; `wreq`↑ with addr 27'h10, data 32'hCAFE0001, no stall → `avm_write` for 1 cycle with those values; `ack` 2 cycles after detection.
- **Stalled read:** `rreq`↑ at addr 27'h10; `waitrequest` held 3 cycles; controller returns 32'h12345678 one cycle after acceptance → `avm_address` stable during the stall; `read_data` = 32'h12345678; `ack` 6 cycles after detection.
- **Simultaneous edges:** `rreq` and `wreq` rise together at addr 27'h20, data 32'hA5A5A5A5 → write then read issued in that order; one `ack`; `read_data` = 32'hA5A5A5A5 from the memory model.
- **Pending request:** second `rreq`↑ while the first read is in RD_WAIT → serviced after the first `ack`; 2 `ack` pulses total; a third edge in the same window sets `err`.
- **Timeout:** `waitrequest` stuck at 1 with `TIMEOUT`=8 → `ack` after 8 command cycles; `read_data` = 32'hDEADBEEF; `err` = 1 and still 1 after the next good transaction.
- **Reset mid-read:** `rst` pulse during RD_WAIT → `avm_read` = 0 and `ack` = 0 immediately; state INIT; a late `readdatavalid` does not update `read_data`.
